// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg
//   Shared definitions for the ALU built-in self-test: ALU operation codes,
//   the order in which operations are applied to each operand pair, the
//   BIST state encoding, the LFSR polynomial and step function, and the
//   four fixed corner-case operand pairs used before the pseudo-random ones.
package alu_bist_pkg;

  // ALU operation codes (MIPS-style aluCtr encoding)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam int NUM_OPS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Corner operand pairs for vector indices 0..3
  localparam logic [31:0] CORNER_A0 = 32'h00000000;
  localparam logic [31:0] CORNER_B0 = 32'h00000000;
  localparam logic [31:0] CORNER_A1 = 32'h12345678;
  localparam logic [31:0] CORNER_B1 = 32'h12345678;
  localparam logic [31:0] CORNER_A2 = 32'h7FFFFFFF;
  localparam logic [31:0] CORNER_B2 = 32'h00000001;
  localparam logic [31:0] CORNER_A3 = 32'h80000000;
  localparam logic [31:0] CORNER_B3 = 32'h00000001;

  // Operation applied at position idx of each vector's op sequence
  function automatic logic [3:0] op_at(input logic [2:0] idx);
    logic [3:0] op;
    case (idx)
      3'd0:    op = OP_AND;
      3'd1:    op = OP_OR;
      3'd2:    op = OP_ADD;
      3'd3:    op = OP_SUB;
      3'd4:    op = OP_SLT;
      3'd5:    op = OP_NOR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] corner_a(input logic [1:0] idx);
    logic [31:0] v;
    case (idx)
      2'd0:    v = CORNER_A0;
      2'd1:    v = CORNER_A1;
      2'd2:    v = CORNER_A2;
      default: v = CORNER_A3;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] corner_b(input logic [1:0] idx);
    logic [31:0] v;
    case (idx)
      2'd0:    v = CORNER_B0;
      2'd1:    v = CORNER_B1;
      2'd2:    v = CORNER_B2;
      default: v = CORNER_B3;
    endcase
    return v;
  endfunction

  // Right-shifting Galois LFSR: the bit shifted out selects the tap mask
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_golden.sv
// alu_golden
//   Combinational reference ALU: expected result and zero flag for the
//   operand pair and op code currently driven to the ALU under test.
//   Unknown op codes yield 0. Self-contained so a CPU bench can reuse it.
// Ports:
//   op_a, op_b  in  32  operands
//   alu_ctr     in   4  operation code
//   result      out 32  expected result (ADD/SUB wrap modulo 2^32)
//   zero        out  1  result == 0
module alu_golden
  import alu_bist_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [3:0]  alu_ctr,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'h0;
    case (alu_ctr)
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_SLT:  result = ($signed(op_a) < $signed(op_b)) ? 32'h1 : 32'h0;
      OP_NOR:  result = ~(op_a | op_b);
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/alu_bist.sv
// alu_bist
//   Built-in self-test sequencer for a 32-bit ALU. Each run applies
//   NUM_VECTORS operand pairs (four corner pairs, then LFSR pairs), each
//   with six operations, and compares the ALU response to alu_golden.
//   Every vector costs 13 cycles: one LOAD plus six DRIVE/CHECK pairs.
// Ports:
//   clk       in   1  clock
//   reset     in   1  asynchronous active-low reset
//   start     in   1  run request, accepted in IDLE or DONE only
//   aluRes    in  32  ALU result
//   zero      in   1  ALU zero flag
//   input1    out 32  operand A to ALU
//   input2    out 32  operand B to ALU
//   aluCtr    out  4  op code to ALU
//   busy      out  1  run in progress
//   done      out  1  run complete
//   pass      out  1  done with no mismatches
//   errCount  out  8  saturating mismatch count
//   failIdx   out  8  vector index of first mismatch
//   failOp    out  4  op code of first mismatch
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE12468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] aluRes,
  input  logic        zero,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [3:0]  aluCtr,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  errCount,
  output logic [7:0]  failIdx,
  output logic [3:0]  failOp
);

  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [2:0] LAST_OP  = 3'(NUM_OPS - 1);

  state_t      state;
  logic [31:0] lfsr;
  logic [7:0]  vec_idx;
  logic [2:0]  op_idx;

  logic [31:0] gold_res;
  logic        gold_zero;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;
  logic [31:0] load_a;
  logic [31:0] load_b;
  logic        mismatch;
  logic [7:0]  err_sat;
  logic [7:0]  err_final;

  alu_golden u_golden (
    .op_a    (input1),
    .op_b    (input2),
    .alu_ctr (aluCtr),
    .result  (gold_res),
    .zero    (gold_zero)
  );

  always_comb begin
    lfsr_a    = lfsr_step(lfsr);
    lfsr_b    = lfsr_step(lfsr_a);
    load_a    = (vec_idx < 8'd4) ? corner_a(vec_idx[1:0]) : lfsr_a;
    load_b    = (vec_idx < 8'd4) ? corner_b(vec_idx[1:0]) : lfsr_b;
    mismatch  = (aluRes != gold_res) || (zero != gold_zero);
    err_sat   = (errCount == 8'hFF) ? errCount : errCount + 8'd1;
    // Count as it will stand after the current CHECK, used for pass at DONE
    err_final = mismatch ? err_sat : errCount;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lfsr     <= SEED;
      vec_idx  <= 8'd0;
      op_idx   <= 3'd0;
      input1   <= 32'h0;
      input2   <= 32'h0;
      aluCtr   <= 4'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      errCount <= 8'd0;
      failIdx  <= 8'd0;
      failOp   <= 4'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_LOAD;
            lfsr     <= SEED;
            vec_idx  <= 8'd0;
            op_idx   <= 3'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            errCount <= 8'd0;
            failIdx  <= 8'd0;
            failOp   <= 4'h0;
          end
        end

        ST_LOAD: begin
          state  <= ST_DRIVE;
          input1 <= load_a;
          input2 <= load_b;
          aluCtr <= op_at(3'd0);
          // Corner vectors do not consume LFSR steps
          if (vec_idx >= 8'd4) begin
            lfsr <= lfsr_b;
          end
        end

        ST_DRIVE: begin
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (mismatch) begin
            errCount <= err_sat;
            if (errCount == 8'd0) begin
              failIdx <= vec_idx;
              failOp  <= aluCtr;
            end
          end
          if (op_idx != LAST_OP) begin
            state  <= ST_DRIVE;
            op_idx <= op_idx + 3'd1;
            aluCtr <= op_at(op_idx + 3'd1);
          end else begin
            op_idx <= 3'd0;
            if (vec_idx != LAST_VEC) begin
              state   <= ST_LOAD;
              vec_idx <= vec_idx + 8'd1;
            end else begin
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_final == 8'd0);
              input1 <= 32'h0;
              input2 <= 32'h0;
              aluCtr <= 4'h0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist
//   Bench for alu_bist with a behavioural ALU that can inject faults.
//   Each run pushes its expected outcome into a queue; a monitor pops and
//   compares when done rises, and also checks the op/operand sequence.
module tb_alu_bist;

  localparam int NV      = 64;
  localparam int RUN_LEN = NV * 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu_res;
  logic        zero_flag;
  logic [31:0] input1_w, input2_w;
  logic [3:0]  alu_ctr_w;
  logic        busy_w, done_w, pass_w;
  logic [7:0]  err_count_w, fail_idx_w;
  logic [3:0]  fail_op_w;

  // 0 good, 1 ADD+1, 2 zero stuck 0, 3 unsigned SLT, 4 every result ^1
  int fault_mode = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int run_active = 0;
  int tally = 0;
  int runs_done = 0;

  typedef struct {
    int         mode;
    logic       pass;
    logic [7:0] err;
    int         use_tally;
    logic [7:0] fidx;
    logic [3:0] fop;
    int         cycles;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_a  [6] = '{32'h0, 32'h12345678, 32'h7FFFFFFF, 32'h80000000, 32'h56709234, 32'h159C248D};
  logic [31:0] exp_b  [6] = '{32'h0, 32'h12345678, 32'h00000001, 32'h00000001, 32'h2B38491A, 32'h8AEE1245};
  logic [3:0]  exp_op [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctr, input int mode);
    logic [31:0] r;
    logic        z;
    case (ctr)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b + ((mode == 1) ? 32'd1 : 32'd0);
      4'b0110: r = a - b;
      4'b0111: begin
        if (mode == 3) r = (a < b) ? 32'd1 : 32'd0;
        else           r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    if (mode == 4) r = r ^ 32'd1;
    z = (r == 32'd0);
    if (mode == 2) z = 1'b0;
    return {z, r};
  endfunction

  assign {zero_flag, alu_res} = alu_model(input1_w, input2_w, alu_ctr_w, fault_mode);

  alu_bist #(.NUM_VECTORS(NV), .SEED(32'hACE12468)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .aluRes   (alu_res),
    .zero     (zero_flag),
    .input1   (input1_w),
    .input2   (input2_w),
    .aluCtr   (alu_ctr_w),
    .busy     (busy_w),
    .done     (done_w),
    .pass     (pass_w),
    .errCount (err_count_w),
    .failIdx  (fail_idx_w),
    .failOp   (fail_op_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {input1_w, input2_w, alu_ctr_w, busy_w, done_w, pass_w,
               err_count_w, fail_idx_w, fail_op_w} == '0, 64'd1);
  endtask

  // Monitor: sequence checks during the run, final compare when done rises
  initial begin : monitor
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (run_active != 0) begin
        int k;
        k = cyc - start_cyc;
        if (k >= 0 && k < RUN_LEN) begin
          int p, v;
          p = k % 13;
          v = k / 13;
          if (p % 2 == 1) begin
            chk("drive_op", {60'd0, alu_ctr_w}, {60'd0, exp_op[(p - 1) / 2]});
            chk("drive_busy", {63'd0, busy_w}, 64'd1);
            if (v < 6 && p == 1)
              chk("drive_operands", {input1_w, input2_w}, {exp_a[v], exp_b[v]});
          end else if (p != 0) begin
            if (alu_model(input1_w, input2_w, alu_ctr_w, fault_mode) !=
                alu_model(input1_w, input2_w, alu_ctr_w, 0))
              tally++;
          end
        end
      end
      if (done_w && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          logic [7:0] exp_err;
          e = sb.pop_front();
          exp_err = (e.use_tally != 0) ? ((tally > 255) ? 8'd255 : 8'(tally)) : e.err;
          $display("run mode=%0d cycles=%0d pass=%0b errCount=%0d failIdx=%0d failOp=%0h (exp pass=%0b err=%0d idx=%0d op=%0h)",
                   e.mode, cyc - start_cyc, pass_w, err_count_w, fail_idx_w, fail_op_w,
                   e.pass, exp_err, e.fidx, e.fop);
          chk("run_length", 64'(cyc - start_cyc), 64'(e.cycles));
          chk("pass", {63'd0, pass_w}, {63'd0, e.pass});
          chk("errCount", {56'd0, err_count_w}, {56'd0, exp_err});
          chk("failIdx", {56'd0, fail_idx_w}, {56'd0, e.fidx});
          chk("failOp", {60'd0, fail_op_w}, {60'd0, e.fop});
          chk("done_outputs_idle", {input1_w, input2_w, alu_ctr_w, busy_w} == '0, 64'd1);
        end
        run_active = 0;
        runs_done++;
      end
      done_q = done_w;
    end
  end

  task automatic issue_start(input int mode);
    @(negedge clk);
    fault_mode = mode;
    tally = 0;
    start = 1'b1;
    start_cyc = cyc + 1;
    run_active = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(input int n_before);
    int ok;
    ok = 0;
    for (int i = 0; i < RUN_LEN + 100; i++) begin
      @(negedge clk);
      if (runs_done > n_before) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      chk("run_timeout", 64'd0, 64'd1);
      sb.delete();
      run_active = 0;
    end
  endtask

  task automatic run_test(input int mode, input logic p, input logic [7:0] err,
                          input int use_tally, input logic [7:0] fidx, input logic [3:0] fop,
                          input int busy_start);
    exp_t e;
    int n;
    e.mode = mode; e.pass = p; e.err = err; e.use_tally = use_tally;
    e.fidx = fidx; e.fop = fop; e.cycles = RUN_LEN;
    sb.push_back(e);
    n = runs_done;
    issue_start(mode);
    if (busy_start != 0) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_run(n);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle_outputs");

    run_test(0, 1'b1, 8'd0,   0, 8'd0, 4'b0000, 0);
    run_test(1, 1'b0, 8'd64,  0, 8'd0, 4'b0010, 0);
    run_test(2, 1'b0, 8'd0,   1, 8'd0, 4'b0000, 0);
    run_test(3, 1'b0, 8'd0,   1, 8'd3, 4'b0111, 0);
    run_test(4, 1'b0, 8'd255, 0, 8'd0, 4'b0000, 0);
    run_test(0, 1'b1, 8'd0,   0, 8'd0, 4'b0000, 1);

    // Mid-run reset with a faulty ALU, then confirm nothing resumes
    issue_start(1);
    repeat (398) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    run_active = 0;
    #1;
    chk_all_zero("midrun_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_resume", {62'd0, busy_w, done_w}, 64'd0);

    run_test(0, 1'b1, 8'd0, 0, 8'd0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
